// File: rtl/pc_sequencer.sv
// Program counter and control-flow unit: jump/call/return, skip, halt,
// hardware return stack and a single-level edge-triggered interrupt.
module pc_sequencer #(
  parameter int unsigned PC_W      = 13,
  parameter int unsigned STK_DEPTH = 8,
  parameter int unsigned IRQ_VEC   = 4,
  parameter int unsigned RST_VEC   = 0
) (
  input  logic                           clk_ip,
  input  logic                           reset_ip,
  input  logic                           jmp_ip,
  input  logic                           call_ip,
  input  logic                           ret_ip,
  input  logic                           reti_ip,
  input  logic                           halt_ip,
  input  logic                           sk_ip,
  input  logic [PC_W-1:0]                target_ip,
  input  logic                           irq_ip,
  input  logic                           irq_en_ip,
  output logic [PC_W-1:0]                prom_addr_op,
  output logic                           irq_ack_op,
  output logic                           in_isr_op,
  output logic [$clog2(STK_DEPTH+1)-1:0] stk_depth_op,
  output logic                           stk_ovf_op,
  output logic                           stk_unf_op
);

  localparam int unsigned DEPTH_W = $clog2(STK_DEPTH + 1);
  localparam int unsigned AW      = $clog2(STK_DEPTH);
  localparam logic [DEPTH_W-1:0] SP_FULL  = DEPTH_W'(STK_DEPTH);
  localparam logic [PC_W-1:0]    IRQ_ADDR = PC_W'(IRQ_VEC);
  localparam logic [PC_W-1:0]    RST_ADDR = PC_W'(RST_VEC);

  logic [PC_W-1:0]    pc;
  logic [DEPTH_W-1:0] sp;
  logic [PC_W-1:0]    stk [STK_DEPTH];
  logic               irq_d;
  logic               pending;
  logic               in_isr;
  logic               ovf;
  logic               unf;

  logic [PC_W-1:0]    pc_nxt;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    pc_skip;
  logic [PC_W-1:0]    push_data;
  logic [PC_W-1:0]    stk_top;
  logic [AW-1:0]      wr_idx;
  logic [AW-1:0]      rd_idx;
  logic               push;
  logic               pop;
  logic               set_ovf;
  logic               set_unf;
  logic               isr_nxt;
  logic               stk_full;
  logic               stk_empty;
  logic               irq_edge;
  logic               take;

  assign pc_inc    = pc + PC_W'(1);
  assign pc_skip   = pc + PC_W'(2);
  assign stk_full  = (sp == SP_FULL);
  assign stk_empty = (sp == '0);
  assign wr_idx    = AW'(sp);
  assign rd_idx    = AW'(sp - DEPTH_W'(1));
  assign stk_top   = stk[rd_idx];
  assign irq_edge  = irq_ip & ~irq_d;

  // A full stack holds the interrupt off rather than losing the return address.
  assign take = ~reset_ip & pending & irq_en_ip & ~in_isr & ~stk_full;

  always_comb begin
    pc_nxt    = pc_inc;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_inc;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    isr_nxt   = in_isr;
    if (take) begin
      // The interrupted instruction is squashed, so its own address is saved.
      push      = 1'b1;
      push_data = pc;
      pc_nxt    = IRQ_ADDR;
      isr_nxt   = 1'b1;
    end else if (halt_ip) begin
      pc_nxt = pc;
    end else if (jmp_ip) begin
      pc_nxt = target_ip;
    end else if (call_ip) begin
      pc_nxt = target_ip;
      if (stk_full) begin
        set_ovf = 1'b1;
      end else begin
        push = 1'b1;
      end
    end else if (ret_ip || reti_ip) begin
      if (reti_ip) begin
        isr_nxt = 1'b0;
      end
      if (stk_empty) begin
        set_unf = 1'b1;
      end else begin
        pop    = 1'b1;
        pc_nxt = stk_top;
      end
    end else if (sk_ip) begin
      pc_nxt = pc_skip;
    end
  end

  always_ff @(posedge clk_ip) begin
    if (reset_ip) begin
      pc      <= RST_ADDR;
      sp      <= '0;
      irq_d   <= 1'b0;
      pending <= 1'b0;
      in_isr  <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      pc     <= pc_nxt;
      irq_d  <= irq_ip;
      in_isr <= isr_nxt;
      // A fresh edge wins over the take so back-to-back requests are kept.
      if (irq_edge) begin
        pending <= 1'b1;
      end else if (take) begin
        pending <= 1'b0;
      end
      if (push) begin
        sp <= sp + DEPTH_W'(1);
      end else if (pop) begin
        sp <= sp - DEPTH_W'(1);
      end
      if (set_ovf) begin
        ovf <= 1'b1;
      end
      if (set_unf) begin
        unf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ip) begin
    if (push && !reset_ip) begin
      stk[wr_idx] <= push_data;
    end
  end

  assign prom_addr_op = pc;
  assign irq_ack_op   = take;
  assign in_isr_op    = in_isr;
  assign stk_depth_op = sp;
  assign stk_ovf_op   = ovf;
  assign stk_unf_op   = unf;

endmodule
